// File: rtl/ram_arbiter_if.sv
// Bus bundle between the work-RAM arbiter, its three requesters (C/B/L) and the RAM macro.
interface ram_arbiter_if;
  logic        c_req, b_req, l_req;
  logic        c_lock, b_lock, l_lock;
  logic        c_wr, b_wr, l_wr;
  logic [11:0] c_addr, b_addr, l_addr;
  logic [7:0]  c_wdata, b_wdata, l_wdata;
  logic        c_ack, b_ack, l_ack;
  logic        c_rvalid, b_rvalid, l_rvalid;
  logic [7:0]  rdata;
  logic        mem_en, mem_wr;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [1:0]  owner;
  logic        lock_err;

  modport slave (
    input  c_req, b_req, l_req, c_lock, b_lock, l_lock, c_wr, b_wr, l_wr,
    input  c_addr, b_addr, l_addr, c_wdata, b_wdata, l_wdata, mem_rdata,
    output c_ack, b_ack, l_ack, c_rvalid, b_rvalid, l_rvalid, rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, owner, lock_err
  );

  modport master (
    output c_req, b_req, l_req, c_lock, b_lock, l_lock, c_wr, b_wr, l_wr,
    output c_addr, b_addr, l_addr, c_wdata, b_wdata, l_wdata, mem_rdata,
    input  c_ack, b_ack, l_ack, c_rvalid, b_rvalid, l_rvalid, rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, owner, lock_err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Chip-8 work-RAM arbiter: L fixed priority, C/B round-robin, optional ownership lock
// with timeout, registered issue stage and a tagged read-return pipeline.
module ram_arbiter #(
  parameter int RAM_LATENCY  = 1,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         res,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_C = 2'd1, OWN_B = 2'd2, OWN_L = 2'd3} owner_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(LOCK_TIMEOUT - 1);
  localparam int         TAIL        = RAM_LATENCY - 1;

  owner_t      owner_q, owner_n, grant;
  logic [7:0]  hold_cnt_q;
  logic [2:0]  ign_q, ign_n;
  logic        rr_b_q, rr_b_n;
  logic        lock_err_q;
  logic [2:0]  req_m, req_raw, lock_raw, lock_eff, own_sel;
  logic        timeout;
  logic        sel_wr;
  logic [11:0] sel_addr;
  logic [7:0]  sel_wdata;

  logic        c_ack_p0, b_ack_p0, l_ack_p0, mem_en_p0, mem_wr_p0;
  logic [11:0] mem_addr_p0;
  logic [7:0]  mem_wdata_p0;
  logic        vld_p  [RAM_LATENCY];
  logic [1:0]  port_p [RAM_LATENCY];

  function automatic logic [2:0] port_mask(owner_t o);
    case (o)
      OWN_C:   return 3'b001;
      OWN_B:   return 3'b010;
      OWN_L:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // A port whose ack is high this cycle is still presenting the access just issued.
  always_comb begin
    req_raw  = {bus.l_req, bus.b_req, bus.c_req};
    req_m    = req_raw & ~{l_ack_p0, b_ack_p0, c_ack_p0};
    lock_raw = {bus.l_lock, bus.b_lock, bus.c_lock};
    lock_eff = lock_raw & ~ign_q;
    own_sel  = port_mask(owner_q);
    timeout  = (owner_q != OWN_NONE) && (hold_cnt_q == TIMEOUT_CNT);
  end

  always_comb begin
    grant     = OWN_NONE;
    owner_n   = owner_q;
    rr_b_n    = rr_b_q;
    ign_n     = ign_q & lock_raw;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (owner_q == OWN_NONE) begin
      if (req_m[2])                            grant = OWN_L;
      else if (req_m[0] && !(req_m[1] && rr_b_q)) grant = OWN_C;
      else if (req_m[1])                       grant = OWN_B;
    end else if ((req_m & own_sel) != 3'b000) begin
      grant = owner_q;
    end
    if (grant == OWN_C)      rr_b_n = 1'b1;
    else if (grant == OWN_B) rr_b_n = 1'b0;
    // A masked cycle with req still high keeps ownership even if lock already dropped.
    if (owner_q == OWN_NONE) begin
      if ((lock_eff & port_mask(grant)) != 3'b000) owner_n = grant;
    end else if (timeout) begin
      owner_n = OWN_NONE;
      ign_n   = ign_n | (own_sel & lock_raw);
    end else if ((lock_eff & own_sel) == 3'b000 &&
                 ((req_raw & own_sel) == 3'b000 || grant != OWN_NONE)) begin
      owner_n = OWN_NONE;
    end
    case (grant)
      OWN_C:   begin sel_wr = bus.c_wr; sel_addr = bus.c_addr; sel_wdata = bus.c_wdata; end
      OWN_B:   begin sel_wr = bus.b_wr; sel_addr = bus.b_addr; sel_wdata = bus.b_wdata; end
      OWN_L:   begin sel_wr = bus.l_wr; sel_addr = bus.l_addr; sel_wdata = bus.l_wdata; end
      default: ;
    endcase
  end

  // Stage p0: arbitration result registered onto the RAM bus
  always_ff @(posedge clk) begin
    if (res) begin
      owner_q      <= OWN_NONE;
      hold_cnt_q   <= 8'd0;
      ign_q        <= 3'b000;
      rr_b_q       <= 1'b0;
      lock_err_q   <= 1'b0;
      c_ack_p0     <= 1'b0;
      b_ack_p0     <= 1'b0;
      l_ack_p0     <= 1'b0;
      mem_en_p0    <= 1'b0;
      mem_wr_p0    <= 1'b0;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
    end else begin
      owner_q      <= owner_n;
      hold_cnt_q   <= (owner_n != owner_q || owner_q == OWN_NONE) ? 8'd0 : hold_cnt_q + 8'd1;
      ign_q        <= ign_n;
      rr_b_q       <= rr_b_n;
      lock_err_q   <= lock_err_q | timeout;
      c_ack_p0     <= (grant == OWN_C);
      b_ack_p0     <= (grant == OWN_B);
      l_ack_p0     <= (grant == OWN_L);
      mem_en_p0    <= (grant != OWN_NONE);
      mem_wr_p0    <= sel_wr;
      mem_addr_p0  <= sel_addr;
      mem_wdata_p0 <= sel_wdata;
    end
  end

  // Stages p[0..RAM_LATENCY-1]: read tags follow the RAM access latency
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < RAM_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= mem_en_p0 & ~mem_wr_p0;
      for (int i = 1; i < RAM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    port_p[0] <= {l_ack_p0 | b_ack_p0, l_ack_p0 | c_ack_p0};
    for (int i = 1; i < RAM_LATENCY; i++) port_p[i] <= port_p[i-1];
  end

  assign bus.c_ack     = c_ack_p0;
  assign bus.b_ack     = b_ack_p0;
  assign bus.l_ack     = l_ack_p0;
  assign bus.mem_en    = mem_en_p0;
  assign bus.mem_wr    = mem_wr_p0;
  assign bus.mem_addr  = mem_addr_p0;
  assign bus.mem_wdata = mem_wdata_p0;
  assign bus.c_rvalid  = vld_p[TAIL] && (port_p[TAIL] == 2'd1);
  assign bus.b_rvalid  = vld_p[TAIL] && (port_p[TAIL] == 2'd2);
  assign bus.l_rvalid  = vld_p[TAIL] && (port_p[TAIL] == 2'd3);
  assign bus.rdata     = bus.mem_rdata;
  assign bus.owner     = owner_q;
  assign bus.lock_err  = lock_err_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: RAM model, read-return scoreboard and per-cycle handshake checks.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic res;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed { logic [1:0] port; logic [7:0] data; } exp_t;
  exp_t       sb [$];
  exp_t       e;
  logic [7:0] ram [4096];
  logic [1:0] mon_port;

  ram_arbiter_if bus();
  ram_arbiter #(.RAM_LATENCY(1), .LOCK_TIMEOUT(64)) dut (.clk(clk), .res(res), .bus(bus));

  always #5 clk = ~clk;

  // Single-port RAM, one cycle read latency; contents preloaded while res is high.
  always @(posedge clk) begin
    if (res) begin
      ram[12'h010] <= 8'h11;
      ram[12'h020] <= 8'h22;
      ram[12'h180] <= 8'h6A;
      ram[12'h2A0] <= 8'h5C;
    end else if (bus.mem_en) begin
      if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input logic req, input logic wr, input logic lock,
                       input logic [11:0] addr, input logic [7:0] wdata);
    bus.c_req = req; bus.c_wr = wr; bus.c_lock = lock; bus.c_addr = addr; bus.c_wdata = wdata;
  endtask

  task automatic set_b(input logic req, input logic wr, input logic lock,
                       input logic [11:0] addr, input logic [7:0] wdata);
    bus.b_req = req; bus.b_wr = wr; bus.b_lock = lock; bus.b_addr = addr; bus.b_wdata = wdata;
  endtask

  task automatic set_l(input logic req, input logic wr, input logic lock,
                       input logic [11:0] addr, input logic [7:0] wdata);
    bus.l_req = req; bus.l_wr = wr; bus.l_lock = lock; bus.l_addr = addr; bus.l_wdata = wdata;
  endtask

  // Read returns are matched in issue order against the scoreboard.
  always @(negedge clk) begin
    if (bus.c_rvalid || bus.b_rvalid || bus.l_rvalid) begin
      mon_port = bus.c_rvalid ? 2'd1 : (bus.b_rvalid ? 2'd2 : 2'd3);
      chk("rv_onehot", 32'($countones({bus.c_rvalid, bus.b_rvalid, bus.l_rvalid})), 32'd1);
      chk("rv_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rv_port", 32'(mon_port), 32'(e.port));
        chk("rv_data", 32'(bus.rdata), 32'(e.data));
      end
    end
  end

  initial begin
    res = 1'b1;
    set_c(0, 0, 0, 12'h000, 8'h00);
    set_b(0, 0, 0, 12'h000, 8'h00);
    set_l(0, 0, 0, 12'h000, 8'h00);
    repeat (3) nxt();
    chk("rst_ctrl", 32'({bus.c_ack, bus.b_ack, bus.l_ack, bus.mem_en, bus.mem_wr, bus.lock_err, bus.owner}), 32'd0);
    chk("rst_addr", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
    chk("rst_rvalid", 32'({bus.c_rvalid, bus.b_rvalid, bus.l_rvalid}), 32'd0);
    res = 1'b0;
    nxt();
    chk("idle_en", 32'(bus.mem_en), 32'd0);

    // Single CPU read
    set_c(1, 0, 0, 12'h180, 8'h00);
    sb.push_back('{2'd1, 8'h6A});
    nxt();
    chk("t1_ack", 32'({bus.c_ack, bus.b_ack, bus.l_ack}), 32'b100);
    chk("t1_bus", 32'({bus.mem_en, bus.mem_wr, bus.mem_addr}), 32'({1'b1, 1'b0, 12'h180}));
    set_c(0, 0, 0, 12'h000, 8'h00);
    nxt();
    chk("t1_rv", 32'({bus.c_rvalid, bus.rdata}), 32'({1'b1, 8'h6A}));
    chk("t1_ack_clr", 32'(bus.c_ack), 32'd0);

    // Single blitter read, leaves the pointer favouring C
    set_b(1, 0, 0, 12'h2A0, 8'h00);
    sb.push_back('{2'd2, 8'h5C});
    nxt();
    chk("t1b_ack", 32'({bus.b_ack, bus.mem_addr}), 32'({1'b1, 12'h2A0}));
    set_b(0, 0, 0, 12'h000, 8'h00);
    nxt();
    chk("t1b_rv", 32'(bus.b_rvalid), 32'd1);

    // C and B compete continuously
    set_c(1, 0, 0, 12'h010, 8'h00);
    set_b(1, 0, 0, 12'h020, 8'h00);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) sb.push_back('{2'd1, 8'h11});
      else            sb.push_back('{2'd2, 8'h22});
      nxt();
      chk("t2_en", 32'(bus.mem_en), 32'd1);
      chk("t2_alt", 32'({bus.c_ack, bus.b_ack}), (k % 2 == 0) ? 32'b10 : 32'b01);
    end
    set_c(0, 0, 0, 12'h000, 8'h00);
    set_b(0, 0, 0, 12'h000, 8'h00);
    nxt();

    // L write overtakes pending C and B; C/B order unchanged by L
    set_c(1, 0, 0, 12'h010, 8'h00);
    set_b(1, 0, 0, 12'h020, 8'h00);
    set_l(1, 1, 0, 12'h400, 8'hA5);
    nxt();
    chk("t3_l_first", 32'({bus.c_ack, bus.b_ack, bus.l_ack}), 32'b001);
    chk("t3_l_bus", 32'({bus.mem_wr, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 12'h400, 8'hA5}));
    set_l(0, 0, 0, 12'h000, 8'h00);
    sb.push_back('{2'd1, 8'h11});
    nxt();
    chk("t3_c_next", 32'({bus.c_ack, bus.b_ack, bus.l_ack}), 32'b100);
    set_c(0, 0, 0, 12'h000, 8'h00);
    sb.push_back('{2'd2, 8'h22});
    nxt();
    chk("t3_b_last", 32'({bus.c_ack, bus.b_ack, bus.l_ack}), 32'b010);
    set_b(0, 0, 0, 12'h000, 8'h00);
    nxt();
    set_c(1, 0, 0, 12'h400, 8'h00);
    sb.push_back('{2'd1, 8'hA5});
    nxt();
    chk("t3_rdback_ack", 32'(bus.c_ack), 32'd1);
    set_c(0, 0, 0, 12'h000, 8'h00);
    nxt();

    // Locked BCD store while B waits
    set_c(1, 1, 1, 12'h300, 8'h01);
    nxt();
    chk("t4_w0", 32'({bus.c_ack, bus.owner, bus.mem_addr}), 32'({1'b1, 2'd1, 12'h300}));
    set_c(1, 1, 1, 12'h301, 8'h02);
    set_b(1, 0, 0, 12'h301, 8'h00);
    nxt();
    chk("t4_gap0", 32'({bus.mem_en, bus.owner}), 32'({1'b0, 2'd1}));
    nxt();
    chk("t4_w1", 32'({bus.c_ack, bus.b_ack, bus.owner, bus.mem_addr}), 32'({2'b10, 2'd1, 12'h301}));
    set_c(1, 1, 0, 12'h302, 8'h03);
    nxt();
    chk("t4_gap1", 32'({bus.mem_en, bus.owner}), 32'({1'b0, 2'd1}));
    nxt();
    chk("t4_w2", 32'({bus.c_ack, bus.owner, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 2'd0, 12'h302, 8'h03}));
    set_c(0, 0, 0, 12'h000, 8'h00);
    sb.push_back('{2'd2, 8'h02});
    nxt();
    chk("t4_b_granted", 32'({bus.b_ack, bus.mem_addr}), 32'({1'b1, 12'h301}));
    set_b(0, 0, 0, 12'h000, 8'h00);
    nxt();
    chk("t4_ram", 32'({ram[12'h300], ram[12'h301], ram[12'h302]}), 32'h010203);

    // Lock timeout: B locks and goes idle while C waits
    set_b(1, 0, 1, 12'h020, 8'h00);
    sb.push_back('{2'd2, 8'h22});
    nxt();
    chk("t5_lock", 32'({bus.b_ack, bus.owner}), 32'({1'b1, 2'd2}));
    set_b(0, 0, 1, 12'h020, 8'h00);
    set_c(1, 0, 0, 12'h010, 8'h00);
    for (int k = 2; k <= 64; k++) begin
      nxt();
      chk("t5_hold", 32'({bus.owner, bus.c_ack, bus.lock_err}), 32'({2'd2, 1'b0, 1'b0}));
    end
    nxt();
    chk("t5_timeout", 32'({bus.owner, bus.lock_err, bus.c_ack}), 32'({2'd0, 1'b1, 1'b0}));
    sb.push_back('{2'd1, 8'h11});
    nxt();
    chk("t5_c_ack", 32'(bus.c_ack), 32'd1);
    set_c(0, 0, 0, 12'h000, 8'h00);
    set_b(1, 0, 1, 12'h020, 8'h00);
    sb.push_back('{2'd2, 8'h22});
    nxt();
    chk("t5_lock_ignored", 32'({bus.b_ack, bus.owner}), 32'({1'b1, 2'd0}));
    set_b(0, 0, 1, 12'h020, 8'h00);
    nxt();
    chk("t5_sticky", 32'({bus.owner, bus.lock_err}), 32'({2'd0, 1'b1}));
    nxt();
    nxt();
    set_b(0, 0, 0, 12'h000, 8'h00);
    nxt();
    set_b(1, 0, 1, 12'h020, 8'h00);
    sb.push_back('{2'd2, 8'h22});
    nxt();
    chk("t5_relock", 32'({bus.b_ack, bus.owner}), 32'({1'b1, 2'd2}));
    set_b(0, 0, 0, 12'h000, 8'h00);
    nxt();
    chk("t5_idle_release", 32'(bus.owner), 32'd0);
    nxt();

    // Reset while a read is in flight
    set_c(1, 0, 0, 12'h180, 8'h00);
    nxt();
    chk("t6_issue", 32'(bus.c_ack), 32'd1);
    res = 1'b1;
    nxt();
    chk("t6_ctrl", 32'({bus.c_ack, bus.b_ack, bus.l_ack, bus.mem_en, bus.mem_wr, bus.lock_err, bus.owner}), 32'd0);
    chk("t6_rvalid", 32'({bus.c_rvalid, bus.b_rvalid, bus.l_rvalid}), 32'd0);
    chk("t6_addr", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
    nxt();
    chk("t6_req_in_res", 32'({bus.c_ack, bus.mem_en}), 32'd0);
    set_c(0, 0, 0, 12'h000, 8'h00);
    res = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) nxt();
    repeat (3) nxt();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 4 KiB Chip-8 work RAM between three requesters: CPU (port C), blitter sprite/scroll fetch (port B) and program loader (port L).
- Registered request/ack handshake, one RAM access per cycle, tagged read-return pipeline.
- Optional lock lets a requester keep ownership across multi-byte sequences (BCD store, Fx55/Fx65 bursts).
- Sits between `cpu`, `blitter`, the loader and the RAM macro.

Parameters:
- RAM_LATENCY, 1, cycles from the RAM sampling mem_en to valid mem_rdata (1..4).
- LOCK_TIMEOUT, 64, maximum consecutive cycles an owner may hold lock before it is overridden (2..255).

Ports:
- clk  in  1  system clock
- res  in  1  synchronous active-high reset
- c_req, b_req, l_req  in  1 each  access request; held with its qualifiers until ack
- c_lock, b_lock, l_lock  in  1 each  request to retain ownership after this access
- c_wr, b_wr, l_wr  in  1 each  1 = write, 0 = read
- c_addr, b_addr, l_addr  in  12 each  byte address
- c_wdata, b_wdata, l_wdata  in  8 each  write data
- c_ack, b_ack, l_ack  out  1 each  one-cycle pulse: access issued to RAM
- c_rvalid, b_rvalid, l_rvalid  out  1 each  one-cycle pulse: rdata is valid for this port
- rdata  out  8  read data, broadcast to all ports (mem_rdata passthrough)
- mem_en  out  1  RAM enable
- mem_wr  out  1  RAM write enable
- mem_addr  out  12  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data
- owner  out  2  current lock owner: 0 none, 1 C, 2 B, 3 L
- lock_err  out  1  sticky lock-timeout flag

Behaviour:
- Reset values:
  - all ack/rvalid outputs 0; mem_en, mem_wr 0; mem_addr, mem_wdata 0.
  - owner 0; lock_err 0; round-robin pointer favours C.
  - read-tag pipeline cleared, so in-flight reads produce no rvalid.
- Issue timing:
  - Requests are sampled in cycle N. The winner's ack and mem_en/mem_wr/mem_addr/mem_wdata are registered and visible in cycle N+1.
  - For reads, the port's rvalid is high in cycle N+1+RAM_LATENCY.
  - When no request is granted, mem_en is 0 in N+1.
- Ack masking: a port's req is ignored in any cycle its ack is high, so an ack is never issued twice. A single port can issue at most one access every 2 cycles; the aggregate rate is 1 access/cycle when ports compete.
- Arbitration, when owner = 0:
  - L has fixed top priority.
  - C and B alternate round-robin. The pointer flips to the other port after each C or B grant and is unchanged by L grants.
- Lock:
  - If the granted request has lock = 1, owner becomes that port in the same cycle its ack rises.
  - While owner ≠ 0, only the owner is eligible. Others stall with req held, and mem_en is 0 in masked cycles.
  - owner returns to 0 the cycle after the owner is sampled with lock = 0. That happens either when a granted access carries lock = 0, or when lock drops while req is low.
- Lock timeout:
  - An 8-bit counter counts cycles with owner ≠ 0; it restarts at each change of owner.
  - When it reaches LOCK_TIMEOUT: owner forced to 0, lock_err set, and that port's lock ignored until it is sampled low.
  - Normal arbitration resumes the next cycle.
- Read tags: a shift register of depth RAM_LATENCY carries {valid, port}; writes insert valid = 0. rvalid is decoded from the tail stage.
- Simultaneous events: lock release and a new request from another port in the same cycle → the other port may be granted the following sample cycle, no idle gap beyond the masked cycle.
- Reset mid-operation overrides everything; requests asserted during res are ignored until the first cycle after res falls.
- Address/data are forwarded unmodified; the 12-bit address wraps naturally (no range check).

Test Plan:
- Single CPU read of 0x180, RAM holds 0x6A → c_ack in N+1, mem_addr = 0x180, c_rvalid in N+2 with rdata = 0x6A (RAM_LATENCY = 1).
- C and B both request reads continuously for 8 cycles → grants alternate C, B, C, B…; mem_en high every cycle; no port acked in two consecutive cycles.
- L requests a write while C and B are pending → L granted first; the C/B order then continues from the pre-L pointer.
- CPU BCD sequence: 3 writes with lock = 1, 1, 0 to 0x300..0x302 while B requests → B stalls until owner = 0, then granted; memory holds the 3 CPU bytes.
- B holds lock = 1 for 70 cycles (LOCK_TIMEOUT = 64) → owner forced to 0 at cycle 64, lock_err = 1, a waiting C acked within 2 cycles.
- Issue a read, assert res in the next cycle → no rvalid emitted, all outputs at reset values the cycle after res.
